// File: rtl/spi_slave_shift_pkg.sv
// Shared definitions for the SPI responder shift engine: default word
// length, FSM state encoding and SPI mode constants.
package spi_slave_shift_pkg;

    localparam int SPI_MAX_LEN = 32;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        logic r;
        case (mode)
            SPI_MODE0, SPI_MODE3: r = 1'b1;
            SPI_MODE1, SPI_MODE2: r = 1'b0;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_slave_shift_sync_edge.sv
// Synchroniser for one asynchronous pad input followed by one edge-detect
// flop. rise/fall are registered single-cycle pulses.
module spi_slave_shift_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic wb_clk,
    input  logic wb_reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, previous-value flop and registered edge pulses.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= level;
            rise   <= level & ~prev_q;
            fall   <= ~level & prev_q;
        end
    end

endmodule

// File: rtl/spi_slave_shift.sv
// SPI responder shift engine. Oversamples sclk/ss_n/mosi in the wb_clk domain,
// deserialises mosi into rx_data and serialises the tx holding register onto miso.
// Optional sticky overrun/underrun flags are built when SPI_SLAVE_ERR_EN is defined.
// Handshakes: tx_load is accepted only in a cycle where tx_ready=1; rx_valid stays
// high until a cycle with rx_ack=1 (unless a new word lands that same cycle).
module spi_slave_shift
    import spi_slave_shift_pkg::*;
#(
    parameter int MAX_LEN     = SPI_MAX_LEN,
    parameter int SYNC_STAGES = 2,
    localparam int LW         = $clog2(MAX_LEN),
    localparam int CW         = $clog2(MAX_LEN + 1)
) (
    input  logic               wb_clk,
    input  logic               wb_reset,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb,
    input  logic [LW-1:0]      len,
    input  logic [MAX_LEN-1:0] tx_data,
    input  logic               tx_load,
    output logic               tx_ready,
    output logic [MAX_LEN-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ack,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    output logic               busy,
    output logic               err_ovr,
    output logic               err_udr,
    input  logic               err_clr
);

    spi_state_t state, next_state;

    logic               sclk_rise, sclk_fall;
    logic               ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic               mosi_s;

    logic [CW-1:0]      word_len;
    logic [CW-1:0]      bit_cnt;
    logic [LW-1:0]      cur_pos;
    logic [MAX_LEN-1:0] tx_shift;
    logic [MAX_LEN-1:0] rx_shift;
    logic [MAX_LEN-1:0] rx_next;
    logic [MAX_LEN-1:0] hold_data;
    logic               hold_full;
    logic [MAX_LEN-1:0] load_word;

    logic               frame_start;
    logic               frame_abort;
    logic               active;
    logic               on_rise;
    logic               sample_edge;
    logic               shift_edge;
    logic               word_done;
    logic               word_start;

    // Position in the word of the idx-th transferred bit for the current bit order.
    function automatic logic [LW-1:0] bit_pos(input logic [CW-1:0] idx,
                                              input logic [CW-1:0] wl,
                                              input logic          lsb_first);
        logic [CW-1:0] p;
        p = lsb_first ? idx : (wl - idx - CW'(1));
        return p[LW-1:0];
    endfunction

    spi_slave_shift_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .wb_clk   (wb_clk),
        .wb_reset (wb_reset),
        .din      (sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_slave_shift_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_ss_sync (
        .wb_clk   (wb_clk),
        .wb_reset (wb_reset),
        .din      (ss_n),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    // Data input only needs the synchroniser; it is sampled on the sclk pulses.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign word_len  = (len == '0) ? CW'(MAX_LEN) : CW'(len);
    assign cur_pos   = bit_pos(bit_cnt, word_len, lsb);
    assign load_word = hold_full ? hold_data : '0;
    assign on_rise   = sample_on_rise({cpol, cpha});

    assign active      = (state == ST_ACTIVE) && !ss_rise;
    assign sample_edge = active && (on_rise ? sclk_rise : sclk_fall);
    assign shift_edge  = active && (on_rise ? sclk_fall : sclk_rise);
    assign word_done   = sample_edge && ((bit_cnt + CW'(1)) == word_len);
    assign word_start  = frame_start || word_done;

    assign busy     = (state == ST_ACTIVE);
    assign miso_oe  = (state == ST_ACTIVE);
    assign tx_ready = ~hold_full;

    // Incoming word with the current mosi bit merged in at its position.
    always_comb begin
        rx_next          = rx_shift;
        rx_next[cur_pos] = mosi_s;
    end

    // FSM state register.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: select falling starts a frame, select rising ends it.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    next_state  = ST_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    next_state  = ST_IDLE;
                    frame_abort = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Shift engine: bit counter, rx/tx shifters and the registered miso bit.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            miso     <= 1'b0;
        end else if (frame_start) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= load_word;
            // cpha=0 presents the first bit before the first sclk edge.
            miso     <= cpha ? 1'b0 : load_word[bit_pos('0, word_len, lsb)];
        end else if (frame_abort) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            miso     <= 1'b0;
        end else if (active) begin
            if (sample_edge) begin
                if (word_done) begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    tx_shift <= load_word;
                end else begin
                    bit_cnt  <= bit_cnt + CW'(1);
                    rx_shift <= rx_next;
                end
            end
            if (shift_edge) begin
                miso <= tx_shift[cur_pos];
            end
        end
    end

    // Receive output register; a completing word wins over a same-cycle ack.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (word_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Transmit holding register; emptied whenever a word moves into the shifter.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (tx_load && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end else if (word_start) begin
            hold_full <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_ERR_EN
    // Sticky error flags; clearing takes priority over a same-cycle set.
    always_ff @(posedge wb_clk or posedge wb_reset) begin
        if (wb_reset) begin
            err_ovr <= 1'b0;
            err_udr <= 1'b0;
        end else if (err_clr) begin
            err_ovr <= 1'b0;
            err_udr <= 1'b0;
        end else begin
            if (word_done && rx_valid && !rx_ack) begin
                err_ovr <= 1'b1;
            end
            if (word_start && !hold_full) begin
                err_udr <= 1'b1;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_ovr        = 1'b0;
    assign err_udr        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: a bit-banged SPI master, a tx feeder,
// an rx consumer and scoreboards of expected rx words and expected miso words.
module tb_spi_slave_shift;

    localparam int MAX_LEN     = 32;
    localparam int SYNC_STAGES = 2;
    localparam int LW          = 5;
    localparam int H           = 8;   // wb_clk cycles per sclk half period
    localparam int SETUP       = 12;  // wb_clk cycles around ss_n edges

`ifdef SPI_SLAVE_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic               wb_clk;
    logic               wb_reset;
    logic               cpol;
    logic               cpha;
    logic               lsb;
    logic [LW-1:0]      len;
    logic [MAX_LEN-1:0] tx_data;
    logic               tx_load;
    logic               tx_ready;
    logic [MAX_LEN-1:0] rx_data;
    logic               rx_valid;
    logic               rx_ack;
    logic               sclk;
    logic               ss_n;
    logic               mosi;
    logic               miso;
    logic               miso_oe;
    logic               busy;
    logic               err_ovr;
    logic               err_udr;
    logic               err_clr;

    int total = 0;
    int bad   = 0;

    logic [MAX_LEN-1:0] exp_q[$];      // expected rx words
    logic [MAX_LEN-1:0] exp_miso_q[$]; // expected words seen on miso
    logic [MAX_LEN-1:0] tx_feed[$];    // words waiting to be loaded
    logic [31:0]        m_tx[4];
    logic [31:0]        m_rx[4];
    bit                 auto_ack;

    spi_slave_shift #(
        .MAX_LEN     (MAX_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_reset (wb_reset),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb      (lsb),
        .len      (len),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .busy     (busy),
        .err_ovr  (err_ovr),
        .err_udr  (err_udr),
        .err_clr  (err_clr)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- tx feeder ----------------
    initial begin
        tx_load = 1'b0;
        tx_data = '0;
        forever begin
            @(negedge wb_clk);
            if (!wb_reset && tx_ready && tx_feed.size() > 0) begin
                tx_data = tx_feed.pop_front();
                tx_load = 1'b1;
                @(negedge wb_clk);
                tx_load = 1'b0;
            end
        end
    end

    // ---------------- rx consumer / scoreboard ----------------
    initial begin
        rx_ack = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (auto_ack && rx_valid && !wb_reset) begin
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("rx_data", rx_data, exp_q.pop_front());
                end
                rx_ack = 1'b1;
                @(negedge wb_clk);
                rx_ack = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_mode(input logic p, input logic h, input logic l, input logic [LW-1:0] n);
        cpol = p;
        cpha = h;
        lsb  = l;
        len  = n;
        sclk = p;
        repeat (SETUP) @(negedge wb_clk);
    endtask

    task automatic load_tx(input logic [31:0] w);
        tx_feed.push_back(w);
        exp_miso_q.push_back(w);
    endtask

    task automatic wait_feed_idle();
        for (int c = 0; c < 50 && (tx_feed.size() != 0 || tx_load); c++) @(negedge wb_clk);
        @(negedge wb_clk);
        chk("feed_idle", 32'(tx_feed.size()), 32'd0);
    endtask

    task automatic wait_rx_drain();
        for (int c = 0; c < 300 && (exp_q.size() != 0 || rx_valid); c++) @(negedge wb_clk);
        chk("rx_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Bit-banged master: nwords words of nbits each; stop_after>0 ends the frame early.
    task automatic spi_xfer(input int nwords, input int nbits, input int stop_after, input bit chk_start);
        int total_bits;
        int w;
        int i;
        int pos;
        int nw;
        int ni;
        total_bits = (stop_after > 0) ? stop_after : nwords * nbits;
        for (int k = 0; k < 4; k++) m_rx[k] = '0;
        sclk = cpol;
        ss_n = 1'b0;
        if (!cpha) mosi = m_tx[0][lsb ? 0 : nbits - 1];
        repeat (SETUP) @(negedge wb_clk);
        if (chk_start) begin
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_miso_oe", 32'(miso_oe), 32'd1);
            chk("start_tx_ready", 32'(tx_ready), 32'd1);
        end
        for (int k = 0; k < total_bits; k++) begin
            w   = k / nbits;
            i   = k % nbits;
            pos = lsb ? i : nbits - 1 - i;
            sclk = ~cpol;
            if (cpha) mosi = m_tx[w][pos];
            else      m_rx[w][pos] = miso;
            repeat (H) @(negedge wb_clk);
            sclk = cpol;
            if (cpha) begin
                m_rx[w][pos] = miso;
            end else if (k + 1 < total_bits) begin
                nw   = (k + 1) / nbits;
                ni   = (k + 1) % nbits;
                mosi = m_tx[nw][lsb ? ni : nbits - 1 - ni];
            end
            repeat (H) @(negedge wb_clk);
        end
        ss_n = 1'b1;
        repeat (SETUP) @(negedge wb_clk);
    endtask

    task automatic check_miso_words(input int nwords);
        for (int k = 0; k < nwords; k++) begin
            if (exp_miso_q.size() == 0) chk("miso_queue", 32'(exp_miso_q.size()), 32'd1);
            else                        chk("miso_word", m_rx[k], exp_miso_q.pop_front());
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        wb_reset = 1'b1;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; len = 5'd8;
        sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; err_clr = 1'b0;
        auto_ack = 1'b1;
        repeat (4) @(negedge wb_clk);
        wb_reset = 1'b0;
        @(negedge wb_clk);

        // Reset values
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_ovr", 32'(err_ovr), 32'd0);
        chk("rst_err_udr", 32'(err_udr), 32'd0);

        // 1: mode 0, MSB first, 8 bits
        set_mode(1'b0, 1'b0, 1'b0, 5'd8);
        load_tx(32'hA5);
        wait_feed_idle();
        chk("t1_tx_ready_full", 32'(tx_ready), 32'd0);
        m_tx[0] = 32'h3C;
        exp_q.push_back(32'h3C);
        spi_xfer(1, 8, 0, 1'b1);
        check_miso_words(1);
        wait_rx_drain();

        // 2: modes 1/2/3, LSB first, 32 bits
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1, 5'd0);
            load_tx(32'hDEADBEEF);
            wait_feed_idle();
            m_tx[0] = 32'h12345678;
            exp_q.push_back(32'h12345678);
            spi_xfer(1, 32, 0, 1'b1);
            check_miso_words(1);
            wait_rx_drain();
        end

        // 3: back-to-back 16-bit words in one frame
        set_mode(1'b0, 1'b0, 1'b0, 5'd16);
        load_tx(32'hA1B2);
        wait_feed_idle();
        load_tx(32'hC3D4);
        load_tx(32'hE5F6);
        m_tx[0] = 32'h1111; m_tx[1] = 32'h2222; m_tx[2] = 32'h3333;
        exp_q.push_back(32'h1111);
        exp_q.push_back(32'h2222);
        exp_q.push_back(32'h3333);
        spi_xfer(3, 16, 0, 1'b0);
        check_miso_words(3);
        wait_rx_drain();

        // 4: overrun and underrun, no ack, no second tx word
        set_mode(1'b0, 1'b0, 1'b0, 5'd8);
        auto_ack = 1'b0;
        load_tx(32'h5A);
        exp_miso_q.push_back(32'h00);
        wait_feed_idle();
        m_tx[0] = 32'h81; m_tx[1] = 32'h7E;
        spi_xfer(2, 8, 0, 1'b0);
        check_miso_words(2);
        chk("t4_rx_data", rx_data, 32'h7E);
        chk("t4_rx_valid", 32'(rx_valid), 32'd1);
        chk("t4_err_ovr", 32'(err_ovr), 32'(ERR_ON));
        chk("t4_err_udr", 32'(err_udr), 32'(ERR_ON));
        err_clr = 1'b1;
        @(negedge wb_clk);
        err_clr = 1'b0;
        @(negedge wb_clk);
        chk("t4_clr_ovr", 32'(err_ovr), 32'd0);
        chk("t4_clr_udr", 32'(err_udr), 32'd0);
        exp_q.push_back(32'h7E);
        auto_ack = 1'b1;
        wait_rx_drain();
        chk("t4_rx_valid_acked", 32'(rx_valid), 32'd0);

        // 5: abort after 5 of 8 bits, then a full frame
        tx_feed.push_back(32'h33);
        wait_feed_idle();
        m_tx[0] = 32'h99;
        spi_xfer(1, 8, 5, 1'b0);
        repeat (20) @(negedge wb_clk);
        chk("t5_rx_valid", 32'(rx_valid), 32'd0);
        chk("t5_miso_oe", 32'(miso_oe), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx_ready", 32'(tx_ready), 32'd1);
        load_tx(32'h96);
        wait_feed_idle();
        m_tx[0] = 32'h69;
        exp_q.push_back(32'h69);
        spi_xfer(1, 8, 0, 1'b0);
        check_miso_words(1);
        wait_rx_drain();

        // 6: reset mid-word, then a full frame
        tx_feed.push_back(32'h0F);
        wait_feed_idle();
        m_tx[0] = 32'hF0;
        fork
            spi_xfer(1, 8, 5, 1'b0);
            begin
                repeat (SETUP + 2 * H * 3 + 4) @(negedge wb_clk);
                chk("t6_busy_before", 32'(busy), 32'd1);
                wb_reset = 1'b1;
                #1;
                chk("t6_busy", 32'(busy), 32'd0);
                chk("t6_miso_oe", 32'(miso_oe), 32'd0);
                chk("t6_miso", 32'(miso), 32'd0);
                chk("t6_rx_valid", 32'(rx_valid), 32'd0);
                chk("t6_tx_ready", 32'(tx_ready), 32'd1);
            end
        join
        repeat (4) @(negedge wb_clk);
        wb_reset = 1'b0;
        repeat (4) @(negedge wb_clk);
        chk("t6_rx_data_rst", rx_data, 32'd0);
        load_tx(32'hC3);
        wait_feed_idle();
        m_tx[0] = 32'h5A;
        exp_q.push_back(32'h5A);
        spi_xfer(1, 8, 0, 1'b1);
        check_miso_words(1);
        wait_rx_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
